// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults and the pixel bus type used along the filter chain
package vga_pkg;

    localparam int DEF_WIDTH        = 640;
    localparam int DEF_HEIGHT       = 480;
    localparam int DEF_H_SYNC_FRONT = 16;
    localparam int DEF_H_SYNC_CYC   = 96;
    localparam int DEF_H_SYNC_BACK  = 48;
    localparam int DEF_V_SYNC_FRONT = 10;
    localparam int DEF_V_SYNC_CYC   = 2;
    localparam int DEF_V_SYNC_BACK  = 33;

    localparam int CW = 13;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       sync_n;
        logic       blank_n;
    } vga_bus_t;

    localparam vga_bus_t VGA_BUS_RESET = '{r: 8'd0, g: 8'd0, b: 8'd0,
                                           hs: 1'b1, vs: 1'b1,
                                           sync_n: 1'b0, blank_n: 1'b0};

endpackage

// File: rtl/vga_timing_counter.sv
// rtl/vga_timing_counter.sv - H/V raster counters with active, sync and pixel-coordinate decodes
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int HEIGHT       = DEF_HEIGHT,
    parameter int H_SYNC_FRONT = DEF_H_SYNC_FRONT,
    parameter int H_SYNC_CYC   = DEF_H_SYNC_CYC,
    parameter int H_SYNC_BACK  = DEF_H_SYNC_BACK,
    parameter int V_SYNC_FRONT = DEF_V_SYNC_FRONT,
    parameter int V_SYNC_CYC   = DEF_V_SYNC_CYC,
    parameter int V_SYNC_BACK  = DEF_V_SYNC_BACK
) (
    input  logic          VGA_CLK,
    input  logic          reset_n,
    output logic          active,
    output logic          hs_n,
    output logic          vs_n,
    output logic          origin,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y
);

    localparam int H_BLANK_I = H_SYNC_FRONT + H_SYNC_CYC + H_SYNC_BACK;
    localparam int V_BLANK_I = V_SYNC_FRONT + V_SYNC_CYC + V_SYNC_BACK;

    localparam logic [CW-1:0] H_BLANK = CW'(H_BLANK_I);
    localparam logic [CW-1:0] V_BLANK = CW'(V_BLANK_I);
    localparam logic [CW-1:0] H_LAST  = CW'(H_BLANK_I + WIDTH - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_BLANK_I + HEIGHT - 1);
    localparam logic [CW-1:0] HS_LO   = CW'(H_SYNC_FRONT);
    localparam logic [CW-1:0] HS_HI   = CW'(H_SYNC_FRONT + H_SYNC_CYC);
    localparam logic [CW-1:0] VS_LO   = CW'(V_SYNC_FRONT);
    localparam logic [CW-1:0] VS_HI   = CW'(V_SYNC_FRONT + V_SYNC_CYC);

    logic [CW-1:0] h;
    logic [CW-1:0] v;

    always_ff @(posedge VGA_CLK) begin
        if (!reset_n) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    always_comb begin
        active = (h >= H_BLANK) && (v >= V_BLANK);
        hs_n   = !((h > HS_LO) && (h <= HS_HI));
        vs_n   = !((v > VS_LO) && (v <= VS_HI));
        origin = (h == '0) && (v == '0);
        x      = active ? h - H_BLANK : '0;
        y      = active ? v - V_BLANK : '0;
    end

endmodule

// File: rtl/vga_stream_source.sv
// rtl/vga_stream_source.sv - VGA stream transmitter fetching pixels over a 1-cycle request/response port
// Optional test pattern generator enabled by VGA_TESTPAT_EN.
module vga_stream_source
    import vga_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int HEIGHT       = DEF_HEIGHT,
    parameter int H_SYNC_FRONT = DEF_H_SYNC_FRONT,
    parameter int H_SYNC_CYC   = DEF_H_SYNC_CYC,
    parameter int H_SYNC_BACK  = DEF_H_SYNC_BACK,
    parameter int V_SYNC_FRONT = DEF_V_SYNC_FRONT,
    parameter int V_SYNC_CYC   = DEF_V_SYNC_CYC,
    parameter int V_SYNC_BACK  = DEF_V_SYNC_BACK
) (
    input  logic          VGA_CLK,
    input  logic          reset_n,
`ifdef VGA_TESTPAT_EN
    input  logic          testpat_sel,
`endif
    output logic          pix_req,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    input  logic [7:0]    pix_r,
    input  logic [7:0]    pix_g,
    input  logic [7:0]    pix_b,
    input  logic          pix_valid,
    input  logic          clr_underflow,
    output logic [7:0]    oVGA_R,
    output logic [7:0]    oVGA_G,
    output logic [7:0]    oVGA_B,
    output logic          oVGA_HS,
    output logic          oVGA_VS,
    output logic          oVGA_SYNC_N,
    output logic          oVGA_BLANK_N,
    output logic          frame_start,
    output logic          underflow,
    output logic [15:0]   frame_count
);

    logic          active;
    logic          hs_n;
    logic          vs_n;
    logic          origin;
    logic [CW-1:0] x;
    logic [CW-1:0] y;

    vga_timing_counter #(
        .WIDTH        (WIDTH),
        .HEIGHT       (HEIGHT),
        .H_SYNC_FRONT (H_SYNC_FRONT),
        .H_SYNC_CYC   (H_SYNC_CYC),
        .H_SYNC_BACK  (H_SYNC_BACK),
        .V_SYNC_FRONT (V_SYNC_FRONT),
        .V_SYNC_CYC   (V_SYNC_CYC),
        .V_SYNC_BACK  (V_SYNC_BACK)
    ) u_timing (
        .VGA_CLK (VGA_CLK),
        .reset_n (reset_n),
        .active  (active),
        .hs_n    (hs_n),
        .vs_n    (vs_n),
        .origin  (origin),
        .x       (x),
        .y       (y)
    );

    assign pix_req = active;
    assign pix_x   = x;
    assign pix_y   = y;

    // Stage 1 holds the decodes while the upstream source prepares the response.
    logic s1_active;
    logic s1_hs;
    logic s1_vs;
    logic s1_origin;

    vga_bus_t out_q;
    logic     miss;
    logic [23:0] rgb_next;

`ifdef VGA_TESTPAT_EN
    logic [7:0] s1_pat_r;
    logic [7:0] s1_pat_g;
    logic [7:0] s1_pat_b;

    always_ff @(posedge VGA_CLK) begin
        if (!reset_n) begin
            s1_pat_r <= '0;
            s1_pat_g <= '0;
            s1_pat_b <= '0;
        end else begin
            s1_pat_r <= x[7:0];
            s1_pat_g <= y[7:0];
            s1_pat_b <= x[7:0] + y[7:0];
        end
    end
`endif

    always_comb begin
        miss     = s1_active && !pix_valid;
        rgb_next = (s1_active && pix_valid) ? {pix_r, pix_g, pix_b} : 24'd0;
`ifdef VGA_TESTPAT_EN
        if (testpat_sel) begin
            miss     = 1'b0;
            rgb_next = s1_active ? {s1_pat_r, s1_pat_g, s1_pat_b} : 24'd0;
        end
`endif
    end

    always_ff @(posedge VGA_CLK) begin
        if (!reset_n) begin
            s1_active   <= 1'b0;
            s1_hs       <= 1'b1;
            s1_vs       <= 1'b1;
            s1_origin   <= 1'b0;
            out_q       <= VGA_BUS_RESET;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            frame_count <= '0;
        end else begin
            s1_active   <= active;
            s1_hs       <= hs_n;
            s1_vs       <= vs_n;
            s1_origin   <= origin;
            out_q       <= '{r: rgb_next[23:16], g: rgb_next[15:8], b: rgb_next[7:0],
                             hs: s1_hs, vs: s1_vs, sync_n: 1'b0, blank_n: s1_active};
            frame_start <= s1_origin;
            if (s1_origin) begin
                frame_count <= frame_count + 16'd1;
            end
            // A miss in the same cycle as a clear must stay visible.
            if (miss) begin
                underflow <= 1'b1;
            end else if (clr_underflow) begin
                underflow <= 1'b0;
            end
        end
    end

    assign oVGA_R       = out_q.r;
    assign oVGA_G       = out_q.g;
    assign oVGA_B       = out_q.b;
    assign oVGA_HS      = out_q.hs;
    assign oVGA_VS      = out_q.vs;
    assign oVGA_SYNC_N  = out_q.sync_n;
    assign oVGA_BLANK_N = out_q.blank_n;

endmodule

// File: tb/tb_vga_stream_source.sv
// tb/tb_vga_stream_source.sv - directed self-checking bench for vga_stream_source at 10x10 resolution
module tb_vga_stream_source;

    localparam int HT = 170;
    localparam int VT = 55;
    localparam int HB = 160;
    localparam int VB = 45;

    logic        VGA_CLK = 1'b0;
    logic        reset_n = 1'b0;
`ifdef VGA_TESTPAT_EN
    logic        testpat_sel = 1'b0;
`endif
    logic        pix_req;
    logic [12:0] pix_x;
    logic [12:0] pix_y;
    logic [7:0]  pix_r = '0;
    logic [7:0]  pix_g = '0;
    logic [7:0]  pix_b = '0;
    logic        pix_valid = 1'b0;
    logic        clr_underflow = 1'b0;
    logic [7:0]  oVGA_R;
    logic [7:0]  oVGA_G;
    logic [7:0]  oVGA_B;
    logic        oVGA_HS;
    logic        oVGA_VS;
    logic        oVGA_SYNC_N;
    logic        oVGA_BLANK_N;
    logic        frame_start;
    logic        underflow;
    logic [15:0] frame_count;

    int checks   = 0;
    int failures = 0;

    bit miss_on = 1'b0;
    int miss_x  = 0;
    int miss_y  = 0;
    bit src_off = 1'b0;

    logic        p_req;
    logic [12:0] p_x;
    logic [12:0] p_y;

    vga_stream_source #(
        .WIDTH  (10),
        .HEIGHT (10)
    ) dut (
        .VGA_CLK       (VGA_CLK),
        .reset_n       (reset_n),
`ifdef VGA_TESTPAT_EN
        .testpat_sel   (testpat_sel),
`endif
        .pix_req       (pix_req),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_r         (pix_r),
        .pix_g         (pix_g),
        .pix_b         (pix_b),
        .pix_valid     (pix_valid),
        .clr_underflow (clr_underflow),
        .oVGA_R        (oVGA_R),
        .oVGA_G        (oVGA_G),
        .oVGA_B        (oVGA_B),
        .oVGA_HS       (oVGA_HS),
        .oVGA_VS       (oVGA_VS),
        .oVGA_SYNC_N   (oVGA_SYNC_N),
        .oVGA_BLANK_N  (oVGA_BLANK_N),
        .frame_start   (frame_start),
        .underflow     (underflow),
        .frame_count   (frame_count)
    );

    initial forever #10 VGA_CLK = ~VGA_CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Upstream source: answers the request seen in cycle n during cycle n+1.
    initial begin
        forever begin
            @(negedge VGA_CLK);
            p_req = pix_req;
            p_x   = pix_x;
            p_y   = pix_y;
            @(posedge VGA_CLK);
            #1;
            if (p_req === 1'b1) begin
                if (src_off || (miss_on && int'(p_x) == miss_x && int'(p_y) == miss_y)) begin
                    pix_r = 8'hFF; pix_g = 8'hFF; pix_b = 8'hFF; pix_valid = 1'b0;
                end else begin
                    pix_r = p_x[7:0]; pix_g = p_y[7:0]; pix_b = p_x[7:0] + p_y[7:0];
                    pix_valid = 1'b1;
                end
            end else begin
                pix_r = 8'h5A; pix_g = 8'h5A; pix_b = 8'h5A; pix_valid = 1'b1;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hs"}, oVGA_HS, 1);
        check({tag, "_vs"}, oVGA_VS, 1);
        check({tag, "_blank_n"}, oVGA_BLANK_N, 0);
        check({tag, "_sync_n"}, oVGA_SYNC_N, 0);
        check({tag, "_rgb"}, {oVGA_R, oVGA_G, oVGA_B}, 0);
        check({tag, "_frame_start"}, frame_start, 0);
        check({tag, "_underflow"}, underflow, 0);
        check({tag, "_frame_count"}, frame_count, 0);
        check({tag, "_pix_req"}, pix_req, 0);
        check({tag, "_pix_xy"}, {pix_x, pix_y}, 0);
    endtask

    task automatic wait_frame_start();
        for (int n = 0; n < HT * VT + 10 && frame_start !== 1'b1; n++) @(negedge VGA_CLK);
        check("frame_start_found", frame_start, 1);
    endtask

    // Called on the negedge where frame_start is high; returns on the next one.
    task automatic run_frame(input string tag, input bit uf_start);
        int hs_lo, vs_lo, bl_hi, hs_err, vs_err, bl_err, rgb_err, uf_err, fs_cnt, sync_err;
        int oh, ov, px, py;
        bit act, uf_exp, is_miss;
        logic [23:0] exp_rgb;
        logic [15:0] fc0;
        hs_lo = 0; vs_lo = 0; bl_hi = 0; hs_err = 0; vs_err = 0; bl_err = 0;
        rgb_err = 0; uf_err = 0; fs_cnt = 0; sync_err = 0;
        uf_exp = uf_start;
        fc0 = frame_count;
        for (int i = 0; i < HT * VT; i++) begin
            oh = i % HT;
            ov = i / HT;
            act = (oh >= HB) && (ov >= VB);
            px = oh - HB;
            py = ov - VB;
            is_miss = act && miss_on && px == miss_x && py == miss_y;
            exp_rgb = (act && !is_miss) ? {8'(px), 8'(py), 8'(px + py)} : 24'd0;
            if (is_miss) uf_exp = 1'b1;
            if (oVGA_HS !== !(oh > 16 && oh <= 112)) hs_err++;
            if (oVGA_VS !== !(ov > 10 && ov <= 12)) vs_err++;
            if (oVGA_BLANK_N !== act) bl_err++;
            if ({oVGA_R, oVGA_G, oVGA_B} !== exp_rgb) rgb_err++;
            if (underflow !== uf_exp) uf_err++;
            if (oVGA_SYNC_N !== 1'b0) sync_err++;
            if (frame_start === 1'b1) fs_cnt++;
            if (oVGA_HS === 1'b0) hs_lo++;
            if (oVGA_VS === 1'b0) vs_lo++;
            if (oVGA_BLANK_N === 1'b1) bl_hi++;
            @(negedge VGA_CLK);
        end
        check({tag, "_hs_low_cycles"}, hs_lo, 96 * VT);
        check({tag, "_hs_pos_err"}, hs_err, 0);
        check({tag, "_vs_low_cycles"}, vs_lo, 2 * HT);
        check({tag, "_vs_pos_err"}, vs_err, 0);
        check({tag, "_blank_hi_cycles"}, bl_hi, 100);
        check({tag, "_blank_pos_err"}, bl_err, 0);
        check({tag, "_rgb_err"}, rgb_err, 0);
        check({tag, "_underflow_err"}, uf_err, 0);
        check({tag, "_sync_n_err"}, sync_err, 0);
        check({tag, "_frame_start_pulses"}, fs_cnt, 1);
        check({tag, "_next_frame_start"}, frame_start, 1);
        check({tag, "_frame_count_step"}, frame_count, 32'(fc0 + 16'd1));
    endtask

    initial begin
        int k;

        // 1: reset and first frame alignment
        reset_n = 1'b0;
        repeat (6) @(posedge VGA_CLK);
        @(negedge VGA_CLK);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        @(negedge VGA_CLK);
        check("fs_release_plus1", frame_start, 0);
        @(negedge VGA_CLK);
        check("fs_release_plus2", frame_start, 1);
        check("fc_first_frame", frame_count, 1);
        k = 2;
        while (pix_req !== 1'b1 && k < HT * VT) begin
            @(negedge VGA_CLK);
            k++;
        end
        check("first_req_cycle", k, VB * HT + HB);
        check("first_req_x", pix_x, 0);
        check("first_req_y", pix_y, 0);
        @(negedge VGA_CLK);
        check("first_req_x_next", pix_x, 1);
        check("blank_before_rise", oVGA_BLANK_N, 0);
        @(negedge VGA_CLK);
        check("blank_rise", oVGA_BLANK_N, 1);

        // 2 and 3: two full frames with a well-behaved source
        wait_frame_start();
        check("fc_frame2", frame_count, 2);
        run_frame("f2", 1'b0);
        run_frame("f3", 1'b0);
        check("fc_after_two", frame_count, 4);
        check("uf_clean_run", underflow, 0);

        // 4: single missing pixel, sticky flag, clear, and set-beats-clear
        miss_on = 1'b1; miss_x = 3; miss_y = 4;
        run_frame("miss", 1'b0);
        miss_on = 1'b0;
        check("uf_sticky", underflow, 1);
        clr_underflow = 1'b1;
        @(negedge VGA_CLK);
        clr_underflow = 1'b0;
        check("uf_cleared", underflow, 0);
        wait_frame_start();
        miss_on = 1'b1; miss_x = 0; miss_y = 0;
        repeat (VB * HT + HB - 1) @(negedge VGA_CLK);
        check("uf_before_miss", underflow, 0);
        clr_underflow = 1'b1;
        @(negedge VGA_CLK);
        clr_underflow = 1'b0;
        check("uf_set_wins", underflow, 1);
        check("miss_blank_n", oVGA_BLANK_N, 1);
        check("miss_rgb_black", {oVGA_R, oVGA_G, oVGA_B}, 0);
        miss_on = 1'b0;

        // 5: one-cycle reset mid-frame
        repeat (5 * HT) @(negedge VGA_CLK);
        reset_n = 1'b0;
        @(negedge VGA_CLK);
        check_reset_outputs("midrst");
        reset_n = 1'b1;
        @(negedge VGA_CLK);
        check("midrst_fs_plus1", frame_start, 0);
        @(negedge VGA_CLK);
        check("midrst_fs_plus2", frame_start, 1);
        check("midrst_fc", frame_count, 1);
        run_frame("after_rst", 1'b0);

`ifdef VGA_TESTPAT_EN
        // 6: internal pattern with a silent source
        testpat_sel = 1'b1;
        src_off = 1'b1;
        run_frame("testpat", 1'b0);
        check("testpat_uf", underflow, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
